// File: rtl/wb_sram_flash_pkg.sv
// Shared types and constants for the Wishbone SRAM/flash bridge.
// The F_HOLD state exists only when ZET_FLASH_WR_EN is defined.
package wb_sram_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_CMD,
        S_W1,
        S_W2,
        F_WAIT,
`ifdef ZET_FLASH_WR_EN
        F_HOLD,
`endif
        ACK
    } state_t;

    localparam logic [3:0] BW_IDLE            = 4'hf;
    localparam logic [3:0] BW_READ            = 4'hc;
    localparam int         FLASH_WAIT_DEFAULT = 4;
    localparam int         TIMER_W            = 4;

endpackage

// File: rtl/wb_sram_flash_if.sv
// Wishbone classic slave bundle: word address, target select (1 = flash), 16-bit data.
interface wb_sram_flash_if;
    logic [20:0] adr;
    logic        tga;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic [1:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (output adr, tga, dat_w, sel, we, stb, cyc, input dat_r, ack);
    modport slave  (input adr, tga, dat_w, sel, we, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/wb_sram_flash_timer.sv
// flash_wait_timer: 4-bit load/down-counter that parks at zero and flags it.
module flash_wait_timer
    import wb_sram_flash_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/wb_sram_flash.sv
// Wishbone bridge to a ZBT SRAM and a NOR flash sharing address/data/oe/we pins.
// FLASH_WAIT (1..15) sets flash access cycles; define ZET_FLASH_WR_EN to enable flash writes.
module wb_sram_flash
    import wb_sram_flash_pkg::*;
#(
    parameter int FLASH_WAIT = FLASH_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_sram_flash_if.slave      wb,
    output logic                sram_clk_,
    output logic [20:0]         sram_flash_addr_,
    inout  wire  [15:0]         sram_flash_data_,
    output logic                sram_flash_oe_n_,
    output logic                sram_flash_we_n_,
    output logic [3:0]          sram_bw_,
    output logic                sram_cen_,
    output logic                flash_ce2_
);

    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(FLASH_WAIT - 1);

    state_t      state;
    logic [15:0] dat_q;
    logic [15:0] rd_q;
    logic        we_q;
    logic        drive;
    logic        ack_q;
    logic        req;
    logic        timer_load;
    logic        timer_zero;

    assign sram_clk_       = clk;
    assign sram_flash_data_ = drive ? dat_q : 16'hzzzz;
    assign wb.dat_r        = rd_q;
    // A master that abandons its cycle never sees the acknowledge.
    assign wb.ack          = ack_q & wb.cyc;
    assign req             = wb.cyc & wb.stb & ~wb.ack;

    always_comb begin
        // NOTE: a default assignment first keeps this combinational block from inferring a latch.
        timer_load = 1'b0;
        if (state == IDLE && req && wb.tga) begin
`ifdef ZET_FLASH_WR_EN
            timer_load = 1'b1;
`else
            timer_load = ~wb.we;
`endif
        end
    end

    flash_wait_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (WAIT_LOAD),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            sram_flash_addr_ <= '0;
            sram_cen_        <= 1'b1;
            flash_ce2_       <= 1'b0;
            sram_flash_oe_n_ <= 1'b1;
            sram_flash_we_n_ <= 1'b1;
            sram_bw_         <= BW_IDLE;
            drive            <= 1'b0;
            dat_q            <= '0;
            rd_q             <= '0;
            we_q             <= 1'b0;
            ack_q            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            case (state)
                IDLE: if (req) begin
                    dat_q <= wb.dat_w;
                    we_q  <= wb.we;
                    if (!wb.tga) begin
                        state            <= S_CMD;
                        sram_flash_addr_ <= wb.adr;
                        sram_cen_        <= 1'b0;
                        sram_flash_oe_n_ <= wb.we;
                        sram_flash_we_n_ <= ~wb.we;
                        sram_bw_         <= wb.we ? {2'b11, ~wb.sel} : BW_READ;
                    end else if (!wb.we) begin
                        state            <= F_WAIT;
                        sram_flash_addr_ <= wb.adr;
                        flash_ce2_       <= 1'b1;
                        sram_flash_oe_n_ <= 1'b0;
                    end else begin
`ifdef ZET_FLASH_WR_EN
                        state            <= F_WAIT;
                        sram_flash_addr_ <= wb.adr;
                        flash_ce2_       <= 1'b1;
                        sram_flash_we_n_ <= 1'b0;
                        drive            <= 1'b1;
`else
                        state            <= ACK;
                        ack_q            <= 1'b1;
`endif
                    end
                end
                // ZBT late write: data goes on the bus two cycles after the command.
                S_CMD: begin
                    state            <= S_W1;
                    sram_cen_        <= 1'b1;
                    sram_flash_we_n_ <= 1'b1;
                    sram_bw_         <= BW_IDLE;
                    drive            <= we_q;
                end
                S_W1: state <= S_W2;
                S_W2: begin
                    state            <= ACK;
                    sram_flash_oe_n_ <= 1'b1;
                    drive            <= 1'b0;
                    ack_q            <= wb.cyc;
                    if (!we_q) rd_q <= sram_flash_data_;
                end
                // After the last active cycle, one turnaround cycle with the flash deselected.
                F_WAIT: if (timer_zero) begin
                    if (!flash_ce2_) begin
                        state <= ACK;
                        ack_q <= wb.cyc;
                    end
`ifdef ZET_FLASH_WR_EN
                    else if (we_q) begin
                        state            <= F_HOLD;
                        sram_flash_we_n_ <= 1'b1;
                    end
`endif
                    else begin
                        rd_q             <= sram_flash_data_;
                        flash_ce2_       <= 1'b0;
                        sram_flash_oe_n_ <= 1'b1;
                    end
                end
`ifdef ZET_FLASH_WR_EN
                F_HOLD: begin
                    state      <= ACK;
                    flash_ce2_ <= 1'b0;
                    drive      <= 1'b0;
                    ack_q      <= wb.cyc;
                end
`endif
                ACK: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_sram_flash.md
WB_SRAM_FLASH -- requirements
Module: wb_sram_flash

Interface
- REQ-001: Parameter FLASH_WAIT, default 4, SHALL set the number of flash access wait cycles (legal range 1..15).
- REQ-002: clk  input  1  system clock; also forwarded unmodified to sram_clk_.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: wb_adr_i  input  21  word address.
- REQ-005: wb_tga_i  input  1  target select: 1 = flash, 0 = SRAM.
- REQ-006: wb_dat_i / wb_dat_o  input / output  16  write / read data.
- REQ-007: wb_sel_i  input  2  byte selects; bit0 = low byte.
- REQ-008: wb_we_i, wb_stb_i, wb_cyc_i  input  1 each  Wishbone classic controls.
- REQ-009: wb_ack_o  output  1  single-cycle acknowledge.
- REQ-010: sram_clk_  output  1  SRAM clock.
- REQ-011: sram_flash_addr_  output  21  shared address bus.
- REQ-012: sram_flash_data_  inout  16  shared data bus.
- REQ-013: sram_flash_oe_n_, sram_flash_we_n_  output  1 each  shared output enable / write enable, active-low.
- REQ-014: sram_bw_  output  4  SRAM byte writes, active-low.
- REQ-015: sram_cen_  output  1  SRAM chip enable, active-low.
- REQ-016: flash_ce2_  output  1  flash chip enable, active-high.

Function
- REQ-017: Pin outputs SHALL be registered.
- REQ-018: A request SHALL be accepted in IDLE when wb_cyc_i & wb_stb_i & !wb_ack_o; address, data, sel, we and tga are latched on acceptance.
- REQ-019: Idle pin state SHALL be: sram_cen_=1, flash_ce2_=0, oe_n=1, we_n=1, bw=4'hf, data bus released (Z), address held.
- REQ-020: States SHALL be IDLE, S_CMD, S_W1, S_W2, F_WAIT, F_HOLD, ACK.
- REQ-021: SRAM read (ZBT, pipelined):
  - S_CMD drives cen_=0, oe_n=0, we_n=1, bw=4'hc.
  - S_W1 and S_W2 deselect: cen_=1, oe_n=0.
  - wb_dat_o SHALL capture the bus at the end of S_W2; ack in ACK.
  - Acceptance-to-ack latency: 4 cycles.
- REQ-022: SRAM write:
  - S_CMD drives cen_=0, we_n=0, bw={2'b11, ~wb_sel_i}.
  - The bus SHALL be driven with the latched data during S_W1 and S_W2 only.
  - Ack latency: 4 cycles.
  - sel=2'b00 SHALL run the cycle with bw=4'hf.
- REQ-023: Flash read:
  - F_WAIT drives flash_ce2_=1, cen_=1, oe_n=0 for FLASH_WAIT cycles.
  - wb_dat_o captures on the last F_WAIT cycle; ack follows.
  - Latency: FLASH_WAIT+2 cycles.
- REQ-024: The block SHALL never drive the data bus in any cycle where oe_n=0.
- REQ-025: wb_ack_o SHALL be high exactly one cycle, and only if wb_cyc_i is still high in ACK. If cyc drops mid-transaction, the pin sequence completes, the ack is suppressed and the block returns to IDLE.
- REQ-026: Back-to-back requests SHALL have at least one IDLE cycle between ack and the next S_CMD/F_WAIT.
- REQ-027: wb_dat_o SHALL hold its value until the next read capture.

Reset
- REQ-028: Asserting rst_n low SHALL immediately force:
  - pins to the idle state, address 0;
  - wb_dat_o=0, wb_ack_o=0;
  - state IDLE.
  An in-flight transaction is abandoned without ack.

Configuration
- REQ-029: With ZET_FLASH_WR_EN defined, a flash write SHALL run as follows:
  - F_WAIT drives flash_ce2_=1, we_n=0, oe_n=1 and the data bus for FLASH_WAIT cycles.
  - F_HOLD drives we_n=1 with data held for one cycle.
  - ACK follows.
- REQ-030: With ZET_FLASH_WR_EN undefined, a flash write SHALL be acked one cycle after acceptance with no pin activity, and F_HOLD SHALL be absent.

Structure
- REQ-031: A shared package SHALL hold:
  - the state enumeration;
  - the idle bw constant 4'hf and the read bw constant 4'hc;
  - the FLASH_WAIT default.
- REQ-032: One sub-module, flash_wait_timer (4-bit load/down-counter with zero flag), SHALL implement the F_WAIT count; everything else is in wb_sram_flash.

Verification
- REQ-033: SRAM write addr 21'h00006, data 16'hA55A, sel 2'b11, then read same address → bw=4'hc in S_CMD; bus=16'hA55A in S_W1/S_W2; read returns 16'hA55A with ack 4 cycles after acceptance.
- REQ-034: SRAM write sel 2'b01, data 16'h1234, over 16'hFFFF → bw=4'hE; readback 16'hFF34.
- REQ-035: Flash read addr 21'h00002 with model data 16'hBEEF, FLASH_WAIT=4 → flash_ce2_=1, oe_n=0 for 4 cycles; wb_dat_o=16'hBEEF; ack 6 cycles after acceptance; sram_cen_ stays 1.
- REQ-036: Flash write, data 16'h00F0:
  - without the macro → ack 1 cycle after acceptance, pins idle;
  - with the macro → we_n low 4 cycles, bus 16'h00F0, ack after F_HOLD.
- REQ-037: rst_n low during S_W1 of an SRAM write → bus Z and pins idle with no clock edge; no ack; next request completes normally.
- REQ-038: Drop wb_cyc_i during F_WAIT → no ack; return to IDLE after sequence end; bus contention checker reports zero cycles with the data bus driven while oe_n=0.
